// File: rtl/poets_stream_arbiter.sv
// Packet-atomic round-robin N-to-1 Avalon-ST merger with a 2-entry
// registered output buffer, source-channel tagging and framing-error pulse.
module poets_stream_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int EMPTY_WIDTH = 2,
   parameter int CH_WIDTH    = 2
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [NUM_CH-1:0]             stream_in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0]  stream_in_data,
   input  logic [NUM_CH-1:0]             stream_in_startofpacket,
   input  logic [NUM_CH-1:0]             stream_in_endofpacket,
   input  logic [NUM_CH*EMPTY_WIDTH-1:0] stream_in_empty,
   output logic [NUM_CH-1:0]             stream_in_ready,
   output logic                          stream_out_valid,
   output logic [DATA_WIDTH-1:0]         stream_out_data,
   output logic                          stream_out_startofpacket,
   output logic                          stream_out_endofpacket,
   output logic [EMPTY_WIDTH-1:0]        stream_out_empty,
   output logic [CH_WIDTH-1:0]           stream_out_channel,
   input  logic                          stream_out_ready,
   output logic                          protocol_err
);

   localparam int BW = DATA_WIDTH + EMPTY_WIDTH + CH_WIDTH + 2;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state, state_nx;
   logic [CH_WIDTH-1:0]     last_grant, grant, cand;
   logic                    grant_valid, room, push, pop, err_nx;
   logic [1:0]              count;
   logic [BW-1:0]           head, tail, beat;
   logic [DATA_WIDTH-1:0]   b_data;
   logic                    b_sop, b_eop;
   logic [EMPTY_WIDTH-1:0]  b_empty;
   int                      idx;

   // Locked owner is always last_grant, since every accepted beat updates it.
   always_comb begin
      grant       = last_grant;
      grant_valid = 1'b0;
      cand        = '0;
      idx         = 0;
      if (state == LOCKED) begin
         grant_valid = stream_in_valid[last_grant];
      end else begin
         for (int i = NUM_CH; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_WIDTH'(idx);
            if (stream_in_valid[cand]) begin
               grant       = cand;
               grant_valid = 1'b1;
            end
         end
      end
   end

   assign room = (count != 2'd2);

   always_comb begin
      stream_in_ready = '0;
      b_data          = '0;
      b_sop           = 1'b0;
      b_eop           = 1'b0;
      b_empty         = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (CH_WIDTH'(c) == grant) begin
            stream_in_ready[c] = grant_valid && room && !reset_reset;
            b_data  = stream_in_data[c*DATA_WIDTH +: DATA_WIDTH];
            b_sop   = stream_in_startofpacket[c];
            b_eop   = stream_in_endofpacket[c];
            b_empty = stream_in_empty[c*EMPTY_WIDTH +: EMPTY_WIDTH];
         end
      end
   end

   assign push = |stream_in_ready;
   assign pop  = stream_out_valid && stream_out_ready;
   assign beat = {b_data, b_sop, b_eop, b_empty, grant};

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (push) begin
               err_nx = !b_sop;
               if (!b_eop) state_nx = LOCKED;
            end
         end
         LOCKED: begin
            if (push) begin
               err_nx = b_sop;
               if (b_eop) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state        <= IDLE;
         last_grant   <= CH_WIDTH'(NUM_CH - 1);
         protocol_err <= 1'b0;
      end else begin
         state        <= state_nx;
         protocol_err <= err_nx;
         if (push) last_grant <= grant;
      end
   end

   // Head-first shift buffer: a push lands in the head slot when it is
   // (or is about to become) empty, otherwise in the tail slot.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop && count == 2'd2) head <= tail;
         if (push) begin
            if (count == 2'd0 || (count == 2'd1 && pop)) head <= beat;
            else tail <= beat;
         end
      end
   end

   assign stream_out_valid = (count != 2'd0);
   assign {stream_out_data, stream_out_startofpacket,
           stream_out_endofpacket, stream_out_empty,
           stream_out_channel} = head;

endmodule

// File: tb/tb_poets_stream_arbiter.sv
// Self-checking bench for poets_stream_arbiter: directed vector table,
// hand sequences and a queue-based reference model under random stimulus.
module tb_poets_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int EW = 2;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      in_valid, in_sop, in_eop, in_ready;
   logic [N*DW-1:0]   in_data;
   logic [N*EW-1:0]   in_empty;
   logic              out_valid, out_sop, out_eop, out_ready, perr;
   logic [DW-1:0]     out_data;
   logic [EW-1:0]     out_empty;
   logic [CW-1:0]     out_ch;

   always #5 clk = ~clk;

   poets_stream_arbiter #(
      .NUM_CH(N), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CH_WIDTH(CW)
   ) dut (
      .clk_clk                 (clk),
      .reset_reset             (rst),
      .stream_in_valid         (in_valid),
      .stream_in_data          (in_data),
      .stream_in_startofpacket (in_sop),
      .stream_in_endofpacket   (in_eop),
      .stream_in_empty         (in_empty),
      .stream_in_ready         (in_ready),
      .stream_out_valid        (out_valid),
      .stream_out_data         (out_data),
      .stream_out_startofpacket(out_sop),
      .stream_out_endofpacket  (out_eop),
      .stream_out_empty        (out_empty),
      .stream_out_channel      (out_ch),
      .stream_out_ready        (out_ready),
      .protocol_err            (perr)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: packets in flight as a queue of beats.
   typedef struct packed {
      logic [31:0] d;
      logic        s;
      logic        e;
      logic [1:0]  m;
      logic [1:0]  c;
   } beat_t;

   beat_t mq[$];
   int    m_owner;
   int    m_last;
   bit    m_err;
   int    sop_order[$];
   int    idle_cnt;

   function automatic int m_grant();
      if (m_owner >= 0) return in_valid[m_owner] ? m_owner : -1;
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (m_last + i) % N;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_cycle(input int cyc, output int acc);
      int           g;
      logic [N-1:0] xr;
      beat_t        b;
      bit           push, pop;
      @(negedge clk);
      g  = m_grant();
      xr = (g >= 0 && mq.size() < 2) ? (4'(1) << g) : 4'(0);
      chk("ready", in_ready, xr);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0)
         chk("head", {out_data, out_sop, out_eop, out_empty, out_ch}, mq[0]);
      chk("protocol_err", perr, m_err);
      if (out_valid && out_ready && out_sop) sop_order.push_back(int'(out_ch));
      if (!out_valid && cyc > 0) idle_cnt++;
      push = (xr != 0);
      pop  = (mq.size() != 0) && out_ready;
      b    = '0;
      if (push) begin
         b.d = in_data[g*DW +: DW];
         b.s = in_sop[g];
         b.e = in_eop[g];
         b.m = in_empty[g*EW +: EW];
         b.c = 2'(g);
      end
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(b);
         m_err   = (m_owner >= 0) ? b.s : !b.s;
         m_last  = g;
         m_owner = b.e ? -1 : g;
         acc     = g;
      end else begin
         m_err = 1'b0;
         acc   = -1;
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s,
                        input logic [N-1:0] e, input logic [7:0] d,
                        input logic [1:0] m, input logic r);
      in_valid  = v;
      in_sop    = s;
      in_eop    = e;
      out_ready = r;
      for (int c = 0; c < N; c++) begin
         in_data[c*DW +: DW]  = 32'(d) + 32'(c * 256);
         in_empty[c*EW +: EW] = m;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, '0, '0, 8'h00, 2'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      m_owner = -1;
      m_last  = N - 1;
      m_err   = 1'b0;
      sop_order.delete();
      idle_cnt = 0;
   endtask

   // rmode: 0 random ready, 1 toggling ready, 2 always ready
   task automatic run_random(input int cycles, input logic [N-1:0] vmask,
                             input int vprob, input int rmode, input int errp,
                             input int minl, input int maxl);
      int len[N];
      int idx[N];
      int acc;
      for (int c = 0; c < N; c++) begin
         idx[c] = 0;
         len[c] = int'($urandom_range(maxl, minl));
      end
      for (int cyc = 0; cyc < cycles; cyc++) begin
         for (int c = 0; c < N; c++) begin
            in_valid[c] = vmask[c] && ($urandom_range(99) < vprob);
            in_sop[c]   = (idx[c] == 0) ^ ($urandom_range(99) < errp);
            in_eop[c]   = (idx[c] == len[c] - 1);
            in_data[c*DW +: DW]  = $urandom;
            in_empty[c*EW +: EW] = 2'($urandom);
         end
         case (rmode)
            1:       out_ready = 1'(cyc % 2);
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(99) < 70);
         endcase
         model_cycle(cyc, acc);
         if (acc >= 0) begin
            idx[acc]++;
            if (idx[acc] == len[acc]) begin
               idx[acc] = 0;
               len[acc] = int'($urandom_range(maxl, minl));
            end
         end
         #1;
      end
   endtask

   typedef struct {
      logic [3:0]  v, s, e;
      logic [7:0]  d;
      logic [1:0]  m;
      logic [3:0]  xr;
      logic        xov;
      logic [31:0] xd;
      logic        xs, xe;
      logic [1:0]  xm, xc;
      logic        xerr;
   } vec_t;

   function automatic vec_t V(
      input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
      input logic [7:0] d, input logic [1:0] m, input logic [3:0] xr,
      input logic xov, input logic [31:0] xd, input logic xs,
      input logic xe, input logic [1:0] xm, input logic [1:0] xc,
      input logic xerr);
      vec_t r;
      r.v = v; r.s = s; r.e = e; r.d = d; r.m = m; r.xr = xr;
      r.xov = xov; r.xd = xd; r.xs = xs; r.xe = xe; r.xm = xm;
      r.xc = xc; r.xerr = xerr;
      return r;
   endfunction

   vec_t vecs[22];
   int   exp_rr[6] = '{0, 1, 3, 0, 1, 3};

   initial begin
      // pass-through of a 3-beat packet on ch2
      vecs[0]  = V(4'b0100, 4'b0100, 4'b0000, 8'hA0, 2'd0, 4'b0100, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[1]  = V(4'b0100, 4'b0000, 4'b0000, 8'hA1, 2'd0, 4'b0100, 1, 32'h2A0, 1, 0, 2'd0, 2'd2, 0);
      vecs[2]  = V(4'b0100, 4'b0000, 4'b0100, 8'hA2, 2'd2, 4'b0100, 1, 32'h2A1, 0, 0, 2'd0, 2'd2, 0);
      vecs[3]  = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 1, 32'h2A2, 0, 1, 2'd2, 2'd2, 0);
      vecs[4]  = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      // beat without SOP while idle
      vecs[5]  = V(4'b0001, 4'b0000, 4'b0001, 8'h55, 2'd0, 4'b0001, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[6]  = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 1, 32'h055, 0, 1, 2'd0, 2'd0, 1);
      vecs[7]  = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      // second SOP inside a ch1 packet
      vecs[8]  = V(4'b0010, 4'b0010, 4'b0000, 8'h10, 2'd0, 4'b0010, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[9]  = V(4'b0011, 4'b0011, 4'b0000, 8'h11, 2'd0, 4'b0010, 1, 32'h110, 1, 0, 2'd0, 2'd1, 0);
      vecs[10] = V(4'b0011, 4'b0001, 4'b0010, 8'h12, 2'd0, 4'b0010, 1, 32'h111, 1, 0, 2'd0, 2'd1, 1);
      vecs[11] = V(4'b0001, 4'b0001, 4'b0001, 8'h13, 2'd0, 4'b0001, 1, 32'h112, 0, 1, 2'd0, 2'd1, 0);
      vecs[12] = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 1, 32'h013, 1, 1, 2'd0, 2'd0, 0);
      vecs[13] = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      // ch1 packet with a 2-cycle gap while ch0 waits
      vecs[14] = V(4'b0011, 4'b0011, 4'b0000, 8'h20, 2'd0, 4'b0010, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[15] = V(4'b0001, 4'b0001, 4'b0000, 8'h21, 2'd0, 4'b0000, 1, 32'h120, 1, 0, 2'd0, 2'd1, 0);
      vecs[16] = V(4'b0001, 4'b0001, 4'b0000, 8'h21, 2'd0, 4'b0000, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[17] = V(4'b0011, 4'b0001, 4'b0000, 8'h22, 2'd0, 4'b0010, 0, 32'h000, 0, 0, 2'd0, 2'd0, 0);
      vecs[18] = V(4'b0011, 4'b0001, 4'b0000, 8'h23, 2'd0, 4'b0010, 1, 32'h122, 0, 0, 2'd0, 2'd1, 0);
      vecs[19] = V(4'b0011, 4'b0001, 4'b0010, 8'h24, 2'd0, 4'b0010, 1, 32'h123, 0, 0, 2'd0, 2'd1, 0);
      vecs[20] = V(4'b0001, 4'b0001, 4'b0001, 8'h25, 2'd0, 4'b0001, 1, 32'h124, 0, 1, 2'd0, 2'd1, 0);
      vecs[21] = V(4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 4'b0000, 1, 32'h025, 1, 1, 2'd0, 2'd0, 0);

      do_reset();
      @(negedge clk);
      chk("reset_ready", in_ready, 0);
      chk("reset_valid_err", {out_valid, perr}, 0);
      chk("reset_fields", {out_data, out_sop, out_eop, out_empty, out_ch}, 0);
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].m, 1'b1);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].xr);
         chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].xov);
         if (vecs[i].xov)
            chk($sformatf("vec%0d_head", i),
                {out_data, out_sop, out_eop, out_empty, out_ch},
                {vecs[i].xd, vecs[i].xs, vecs[i].xe, vecs[i].xm, vecs[i].xc});
         chk($sformatf("vec%0d_err", i), perr, vecs[i].xerr);
         @(posedge clk);
         #1;
      end

      // round-robin over ch0, ch1, ch3 with 2-beat packets
      do_reset();
      run_random(40, 4'b1011, 100, 2, 0, 2, 2);
      chk("rr_idle_cycles", 64'(idle_cnt), 0);
      chk("rr_packets", 64'(sop_order.size() >= 6), 1);
      for (int i = 0; i < 6; i++)
         if (i < sop_order.size())
            chk($sformatf("rr_order%0d", i), 64'(sop_order[i]), 64'(exp_rr[i]));

      // toggling backpressure on 5-beat packets
      do_reset();
      run_random(60, 4'b0100, 100, 1, 0, 5, 5);

      // reset in the middle of a ch2 packet
      do_reset();
      drive(4'b0100, 4'b0100, 4'b0000, 8'h30, 2'd0, 1'b0);
      @(negedge clk);
      chk("mid_rst_rdy0", in_ready, 4'b0100);
      @(posedge clk);
      #1;
      drive(4'b0100, 4'b0000, 4'b0000, 8'h31, 2'd0, 1'b0);
      @(negedge clk);
      chk("mid_rst_rdy1", in_ready, 4'b0100);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(4'b0100, 4'b0000, 4'b0000, 8'h32, 2'd0, 1'b0);
      @(negedge clk);
      chk("mid_rst_full", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive('0, '0, '0, 8'h00, 2'd0, 1'b1);
      @(negedge clk);
      chk("mid_rst_outputs",
          {out_valid, out_data, out_sop, out_eop, out_empty, out_ch, perr, in_ready}, 0);
      @(posedge clk);
      #1;
      drive(4'b1001, 4'b1001, 4'b1001, 8'h40, 2'd1, 1'b1);
      @(negedge clk);
      chk("post_rst_prio", in_ready, 4'b0001);
      @(posedge clk);
      #1;
      drive(4'b1000, 4'b1000, 4'b1000, 8'h41, 2'd1, 1'b1);
      @(negedge clk);
      chk("post_rst_rdy3", in_ready, 4'b1000);
      chk("post_rst_ch0", {out_valid, out_data, out_ch}, {1'b1, 32'h040, 2'd0});
      @(posedge clk);
      #1;
      drive('0, '0, '0, 8'h00, 2'd0, 1'b1);
      @(negedge clk);
      chk("post_rst_ch3", {out_valid, out_data, out_eop, out_ch},
          {1'b1, 32'h341, 1'b1, 2'd3});
      @(posedge clk);
      #1;

      // long random run with framing errors and random backpressure
      do_reset();
      run_random(3000, 4'b1111, 60, 0, 10, 1, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
